// File: rtl/deserializer_pkg.sv
// Shared accelerator package: fixed-point word defaults and deserializer state encoding.
package deserializer_pkg;

  // Default width of one fixed-point word across the accelerator datapath.
  localparam int unsigned Q_SIZE_DEFAULT = 16;

  // One fixed-point word at the default accelerator width.
  typedef logic [Q_SIZE_DEFAULT-1:0] q_word_t;

  // IDLE: no words held (word_count == 0); FILL: 1..OUTPUT_SIZE-1 words held.
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_FILL = 1'b1
  } des_state_e;

endpackage : deserializer_pkg

// File: rtl/deserializer.sv
// Deserializer: assembles OUTPUT_SIZE serial fixed-point words into one packed vector.
//
// Ports
//   clk          : clock, all state updates on posedge
//   rst_n        : asynchronous active-low reset
//   serial_valid : serial_in carries a word this cycle
//   frame_start  : with serial_valid, marks the current word as element 0 of a new vector
//   serial_in    : serial word, element 0 first
//   error_clear  : synchronous clear of frame_error (a same-cycle new error wins)
//   data_out     : last completed vector, element 0 at index 0; held between completions
//   data_valid   : one-cycle pulse, data_out newly updated
//   word_count   : words accepted into the vector in progress
//   frame_error  : sticky, a partial vector was abandoned by frame_start
//
// OUTPUT_SIZE must be at least 2.
module deserializer
  import deserializer_pkg::*;
#(
  parameter int unsigned OUTPUT_SIZE = 4,
  parameter int unsigned Q_SIZE      = Q_SIZE_DEFAULT
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  serial_valid,
  input  logic                                  frame_start,
  input  logic [Q_SIZE-1:0]                     serial_in,
  input  logic                                  error_clear,
  output logic [OUTPUT_SIZE-1:0][Q_SIZE-1:0]    data_out,
  output logic                                  data_valid,
  output logic [$clog2(OUTPUT_SIZE+1)-1:0]      word_count,
  output logic                                  frame_error
);

  localparam int unsigned CNT_W = $clog2(OUTPUT_SIZE + 1);

  des_state_e                             state_q, state_d;
  logic [CNT_W-1:0]                       cnt_q, cnt_d;
  logic [OUTPUT_SIZE-1:0][Q_SIZE-1:0]     shreg_q, shreg_d;
  logic [OUTPUT_SIZE-1:0][Q_SIZE-1:0]     dout_q, dout_d;
  logic                                   dv_q, dv_d;
  logic                                   err_q, err_d;

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      shreg_q <= '0;
      dout_q  <= '0;
      dv_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shreg_q <= shreg_d;
      dout_q  <= dout_d;
      dv_q    <= dv_d;
      err_q   <= err_d;
    end
  end

  // Next-state: accept, count, restart on frame_start, publish on the last word.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shreg_d = shreg_q;
    dout_d  = dout_q;
    dv_d    = 1'b0;
    err_d   = err_q;

    if (error_clear) begin
      err_d = 1'b0;
    end

    if (serial_valid) begin
      // Newest word enters at the top so element 0 lands at index 0 after a full vector.
      // A restart needs no flush: stale words are shifted out before the vector completes.
      shreg_d = {serial_in, shreg_q[OUTPUT_SIZE-1:1]};

      unique case (state_q)
        ST_IDLE: begin
          state_d = ST_FILL;
          cnt_d   = CNT_W'(1);
        end
        ST_FILL: begin
          if (frame_start) begin
            // Abandon the partial vector; this word becomes element 0. Set beats clear.
            err_d = 1'b1;
            cnt_d = CNT_W'(1);
          end else if (cnt_q == CNT_W'(OUTPUT_SIZE - 1)) begin
            dout_d  = shreg_d;
            dv_d    = 1'b1;
            cnt_d   = '0;
            state_d = ST_IDLE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  assign data_out    = dout_q;
  assign data_valid  = dv_q;
  assign word_count  = cnt_q;
  assign frame_error = err_q;

endmodule : deserializer

// File: tb/tb_deserializer.sv
// Self-checking bench for deserializer (OUTPUT_SIZE=4, Q_SIZE=8): directed cases plus random traffic
// against a queue-based model of the vector assembly rules.
module tb_deserializer;

  localparam int unsigned N = 4;
  localparam int unsigned W = 8;

  logic                   clk = 1'b0;
  logic                   rst_n = 1'b1;
  logic                   serial_valid = 1'b0;
  logic                   frame_start = 1'b0;
  logic [W-1:0]           serial_in = '0;
  logic                   error_clear = 1'b0;
  logic [N-1:0][W-1:0]    data_out;
  logic                   data_valid;
  logic [2:0]             word_count;
  logic                   frame_error;

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  deserializer #(.OUTPUT_SIZE(N), .Q_SIZE(W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .serial_valid (serial_valid),
    .frame_start  (frame_start),
    .serial_in    (serial_in),
    .error_clear  (error_clear),
    .data_out     (data_out),
    .data_valid   (data_valid),
    .word_count   (word_count),
    .frame_error  (frame_error)
  );

  always #5 clk = ~clk;

  // Behavioural model: the words of the vector in progress as a queue.
  logic [W-1:0]        cur[$];
  logic [N*W-1:0]      m_dout;
  logic                m_dv;
  logic                m_err;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur.delete();
      m_dout = '0;
      m_dv   = 1'b0;
      m_err  = 1'b0;
    end else begin
      m_dv = 1'b0;
      if (error_clear) m_err = 1'b0;
      if (serial_valid) begin
        if (frame_start && cur.size() != 0) begin
          m_err = 1'b1;
          cur.delete();
        end
        cur.push_back(serial_in);
        if (cur.size() == N) begin
          for (int i = 0; i < int'(N); i++) m_dout[i*W +: W] = cur[i];
          m_dv = 1'b1;
          cur.delete();
        end
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Cycle-by-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("data_valid",  64'(data_valid),  64'(m_dv));
      chk("data_out",    64'(data_out),    64'(m_dout));
      chk("word_count",  64'(word_count),  64'(cur.size()));
      chk("frame_error", 64'(frame_error), 64'(m_err));
    end
  end

  task automatic drive(input logic v, input logic fs, input logic [W-1:0] w, input logic ec);
    @(negedge clk);
    serial_valid = v;
    frame_start  = fs;
    serial_in    = w;
    error_clear  = ec;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, '0, 1'b0);
  endtask

  task automatic reset_pulse(input int n);
    @(negedge clk);
    serial_valid = 1'b0;
    frame_start  = 1'b0;
    error_clear  = 1'b0;
    #2 rst_n = 1'b0;
    repeat (n) @(negedge clk);
    #2 rst_n = 1'b1;
  endtask

  logic [W-1:0] ser_data [N];
  int pulses;
  int first_pulse;
  int gap;

  initial begin
    #1 rst_n = 1'b0;
    chk_en = 1'b1;
    repeat (2) @(negedge clk);
    chk("reset data_out", 64'(data_out), 64'h0);
    chk("reset word_count", 64'(word_count), 64'h0);
    #2 rst_n = 1'b1;

    // Four consecutive words.
    drive(1, 0, 8'h11, 0); drive(1, 0, 8'h22, 0); drive(1, 0, 8'h33, 0); drive(1, 0, 8'h44, 0);
    drive(0, 0, 8'h00, 0);
    chk("basic valid", 64'(data_valid), 64'h1);
    chk("basic data", 64'(data_out), 64'h44332211);
    drive(0, 0, 8'h00, 0);
    chk("basic valid one cycle", 64'(data_valid), 64'h0);

    // Bubbles between 2nd and 3rd word.
    pulses = 0;
    drive(1, 0, 8'h11, 0); drive(1, 0, 8'h22, 0);
    for (int i = 0; i < 3; i++) begin drive(0, 0, 8'hEE, 0); pulses += int'(data_valid); end
    drive(1, 0, 8'h33, 0); pulses += int'(data_valid);
    drive(1, 0, 8'h44, 0); pulses += int'(data_valid);
    for (int i = 0; i < 3; i++) begin drive(0, 0, 8'h00, 0); pulses += int'(data_valid); end
    chk("bubble pulses", 64'(pulses), 64'd1);
    chk("bubble data", 64'(data_out), 64'h44332211);

    // Eight back-to-back words: two pulses four cycles apart.
    pulses = 0; first_pulse = -1; gap = 0;
    for (int i = 1; i <= 8; i++) begin
      drive(1, 0, W'(i), 0);
      if (data_valid) begin pulses++; if (first_pulse < 0) first_pulse = i; else gap = i - first_pulse; end
      if (i == 5) chk("b2b first vector", 64'(data_out), 64'h04030201);
    end
    drive(0, 0, 8'h00, 0);
    if (data_valid) begin pulses++; gap = 9 - first_pulse; end
    chk("b2b pulses", 64'(pulses), 64'd2);
    chk("b2b gap", 64'(gap), 64'd4);
    chk("b2b second vector", 64'(data_out), 64'h08070605);

    // Restart by frame_start mid-vector.
    drive(1, 0, 8'hA1, 0); drive(1, 0, 8'hA2, 0);
    drive(1, 1, 8'hB1, 0);
    drive(1, 0, 8'hB2, 0);
    chk("restart count", 64'(word_count), 64'd1);
    chk("restart data held", 64'(data_out), 64'h08070605);
    drive(1, 0, 8'hB3, 0); drive(1, 0, 8'hB4, 0);
    drive(0, 0, 8'h00, 0);
    chk("restart error", 64'(frame_error), 64'h1);
    chk("restart data", 64'(data_out), 64'hB4B3B2B1);

    // Set wins over a same-cycle clear, then a plain clear.
    drive(1, 0, 8'h01, 0);
    drive(1, 1, 8'h02, 1);
    drive(0, 0, 8'h00, 0);
    chk("set wins", 64'(frame_error), 64'h1);
    drive(0, 0, 8'h00, 1);
    drive(0, 0, 8'h00, 0);
    chk("error clear", 64'(frame_error), 64'h0);
    reset_pulse(1);

    // Reset mid-vector.
    drive(1, 0, 8'hD1, 0); drive(1, 0, 8'hD2, 0); drive(1, 0, 8'hD3, 0);
    reset_pulse(2);
    chk("midreset data_out", 64'(data_out), 64'h0);
    chk("midreset word_count", 64'(word_count), 64'h0);
    drive(1, 0, 8'hC1, 0); drive(1, 0, 8'hC2, 0); drive(1, 0, 8'hC3, 0); drive(1, 0, 8'hC4, 0);
    drive(0, 0, 8'h00, 0);
    chk("post reset data", 64'(data_out), 64'hC4C3C2C1);

    // Loopback from a serializer emitting data[0], data[1], ...
    ser_data[0] = 8'h10; ser_data[1] = 8'h20; ser_data[2] = 8'h30; ser_data[3] = 8'h40;
    for (int i = 0; i < int'(N); i++) drive(1, (i == 0), ser_data[i], 0);
    drive(0, 0, 8'h00, 0);
    chk("loopback", 64'(data_out), 64'h40302010);

    // Random traffic with bursts, restarts, clears and occasional resets.
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 399) == 0) begin
        reset_pulse($urandom_range(1, 3));
      end else if (i % 500 < 40) begin
        drive(1, 0, W'($urandom), 0);
      end else begin
        drive($urandom_range(0, 99) < 70, $urandom_range(0, 99) < 8, W'($urandom),
              $urandom_range(0, 99) < 5);
      end
    end
    idle(3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_deserializer
